// File: rtl/tx_frame_scheduler.sv
// Shares one UART tx_unit between two ADC channels: one pending sample per channel,
// round-robin grant, and each sample sent as a header/high/low byte frame.
module tx_frame_scheduler #(
    parameter int                      DATA_SIZE    = 14,
    parameter int                      TX_DATA_SIZE = 8,
    parameter logic [TX_DATA_SIZE-2:0] SYNC_TAG     = 7'h52
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic                    i_valid_ch1,
    input  logic [DATA_SIZE-1:0]    i_data_ch1,
    input  logic                    i_valid_ch2,
    input  logic [DATA_SIZE-1:0]    i_data_ch2,
    input  logic                    i_txready,
    output logic                    o_send,
    output logic [TX_DATA_SIZE-1:0] o_txdata,
    output logic                    o_busy,
    output logic                    o_overflow_ch1,
    output logic                    o_overflow_ch2,
    output logic [15:0]             o_frame_count
);

    localparam int EXT_W = 2 * TX_DATA_SIZE;

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_HI, ST_LO} byte_state_t;
    typedef enum logic [1:0] {PH_ISSUE, PH_ACK, PH_DONE} phase_t;

    byte_state_t state, state_nxt;
    phase_t      phase, phase_nxt;

    logic                 pending_ch1, pending_ch2;
    logic [DATA_SIZE-1:0] hold_ch1, hold_ch2;
    logic [DATA_SIZE-1:0] frame_data;
    logic                 frame_ch;
    logic                 last_grant_ch2;
    logic                 grant_ch1, grant_ch2;
    logic                 frame_done;
    logic [EXT_W-1:0]     frame_ext;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
            phase <= PH_ISSUE;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        o_send     = 1'b0;
        grant_ch1  = 1'b0;
        grant_ch2  = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_txready && (pending_ch1 || pending_ch2)) begin
                    if (pending_ch1 && (!pending_ch2 || last_grant_ch2))
                        grant_ch1 = 1'b1;
                    else
                        grant_ch2 = 1'b1;
                    state_nxt = ST_HDR;
                    phase_nxt = PH_ISSUE;
                end
            end
            default: begin
                case (phase)
                    PH_ISSUE: begin
                        // Gated by i_txready so a send is never offered to a busy tx_unit.
                        if (i_txready) begin
                            o_send    = 1'b1;
                            phase_nxt = PH_ACK;
                        end
                    end
                    PH_ACK: begin
                        if (!i_txready)
                            phase_nxt = PH_DONE;
                    end
                    PH_DONE: begin
                        if (i_txready) begin
                            phase_nxt = PH_ISSUE;
                            case (state)
                                ST_HDR:  state_nxt = ST_HI;
                                ST_HI:   state_nxt = ST_LO;
                                default: begin
                                    state_nxt  = ST_IDLE;
                                    frame_done = 1'b1;
                                end
                            endcase
                        end
                    end
                    default: phase_nxt = PH_ISSUE;
                endcase
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            pending_ch1    <= 1'b0;
            pending_ch2    <= 1'b0;
            hold_ch1       <= '0;
            hold_ch2       <= '0;
            frame_data     <= '0;
            frame_ch       <= 1'b0;
            last_grant_ch2 <= 1'b1;
            o_overflow_ch1 <= 1'b0;
            o_overflow_ch2 <= 1'b0;
            o_frame_count  <= '0;
        end else begin
            if (grant_ch1) begin
                frame_data     <= hold_ch1;
                frame_ch       <= 1'b0;
                last_grant_ch2 <= 1'b0;
            end
            if (grant_ch2) begin
                frame_data     <= hold_ch2;
                frame_ch       <= 1'b1;
                last_grant_ch2 <= 1'b1;
            end

            // A slot being granted on this edge is free for a new sample.
            if (i_enable && i_valid_ch1) begin
                if (!pending_ch1 || grant_ch1) begin
                    hold_ch1    <= i_data_ch1;
                    pending_ch1 <= 1'b1;
                end else begin
                    o_overflow_ch1 <= 1'b1;
                end
            end else if (grant_ch1) begin
                pending_ch1 <= 1'b0;
            end

            if (i_enable && i_valid_ch2) begin
                if (!pending_ch2 || grant_ch2) begin
                    hold_ch2    <= i_data_ch2;
                    pending_ch2 <= 1'b1;
                end else begin
                    o_overflow_ch2 <= 1'b1;
                end
            end else if (grant_ch2) begin
                pending_ch2 <= 1'b0;
            end

            if (frame_done)
                o_frame_count <= o_frame_count + 16'd1;
        end
    end

    assign frame_ext = EXT_W'(frame_data);

    always_comb begin
        o_txdata = '0;
        case (state)
            ST_HDR:  o_txdata = {SYNC_TAG, frame_ch};
            ST_HI:   o_txdata = frame_ext[EXT_W-1:TX_DATA_SIZE];
            ST_LO:   o_txdata = frame_ext[TX_DATA_SIZE-1:0];
            default: o_txdata = '0;
        endcase
    end

    assign o_busy = (state != ST_IDLE) | pending_ch1 | pending_ch2;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler: a tx_unit responder logs every sent byte,
// and the main sequence compares them against a queue of expected frame bytes.
module tb_tx_frame_scheduler;

    logic        i_clock;
    logic        i_reset;
    logic        i_enable;
    logic        i_valid_ch1;
    logic [13:0] i_data_ch1;
    logic        i_valid_ch2;
    logic [13:0] i_data_ch2;
    logic        i_txready;
    logic        o_send;
    logic [7:0]  o_txdata;
    logic        o_busy;
    logic        o_overflow_ch1;
    logic        o_overflow_ch2;
    logic [15:0] o_frame_count;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         rd_ptr     = 0;
    int         send_total = 0;
    int         viol_cnt   = 0;
    int         busy_left  = 0;
    logic       tx_stall   = 1'b0;

    tx_frame_scheduler dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_valid_ch1    (i_valid_ch1),
        .i_data_ch1     (i_data_ch1),
        .i_valid_ch2    (i_valid_ch2),
        .i_data_ch2     (i_data_ch2),
        .i_txready      (i_txready),
        .o_send         (o_send),
        .o_txdata       (o_txdata),
        .o_busy         (o_busy),
        .o_overflow_ch1 (o_overflow_ch1),
        .o_overflow_ch2 (o_overflow_ch2),
        .o_frame_count  (o_frame_count)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // tx_unit model: drops ready one cycle after a send and raises it 10 cycles later.
    initial begin
        i_txready = 1'b1;
        forever begin
            @(negedge i_clock);
            if (o_send === 1'b1) begin
                got_q.push_back(o_txdata);
                send_total++;
                if (i_txready !== 1'b1) viol_cnt++;
                busy_left = 11;
            end
            @(posedge i_clock);
            #1;
            if (busy_left > 0) busy_left--;
            i_txready = !tx_stall && (busy_left == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic ch, input logic [13:0] data);
        exp_q.push_back({7'h52, ch});
        exp_q.push_back({2'b00, data[13:8]});
        exp_q.push_back(data[7:0]);
    endtask

    task automatic drain();
        while (rd_ptr < got_q.size()) begin
            if (exp_q.size() == 0)
                check("unexpected_byte", {24'h0, got_q[rd_ptr]}, 32'h100);
            else
                check("tx_byte", {24'h0, got_q[rd_ptr]}, {24'h0, exp_q.pop_front()});
            rd_ptr++;
        end
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 1500 && !done; i++) begin
            @(negedge i_clock);
            drain();
            if (o_busy === 1'b0 && i_txready === 1'b1 && exp_q.size() == 0) done = 1'b1;
        end
        check({tag, "_idle_reached"}, {31'h0, done}, 32'h1);
    endtask

    task automatic strobe(input logic v1, input logic [13:0] d1,
                          input logic v2, input logic [13:0] d2);
        i_valid_ch1 = v1;
        i_data_ch1  = d1;
        i_valid_ch2 = v2;
        i_data_ch2  = d2;
        @(posedge i_clock);
        #1;
        i_valid_ch1 = 1'b0;
        i_valid_ch2 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_send"},  {31'h0, o_send},         32'h0);
        check({tag, "_txdata"}, {24'h0, o_txdata},      32'h0);
        check({tag, "_busy"},  {31'h0, o_busy},         32'h0);
        check({tag, "_ovf1"},  {31'h0, o_overflow_ch1}, 32'h0);
        check({tag, "_ovf2"},  {31'h0, o_overflow_ch2}, 32'h0);
        check({tag, "_count"}, {16'h0, o_frame_count},  32'h0);
    endtask

    task automatic do_reset(input string tag);
        i_reset = 1'b0;
        #1;
        check_reset_outputs(tag);
        repeat (3) @(posedge i_clock);
        #1;
        i_reset = 1'b1;
    endtask

    initial begin
        int   s0;
        logic found;

        i_reset     = 1'b1;
        i_enable    = 1'b1;
        i_valid_ch1 = 1'b0;
        i_valid_ch2 = 1'b0;
        i_data_ch1  = '0;
        i_data_ch2  = '0;
        #1;
        do_reset("rst0");

        // Single ch1 sample.
        s0 = send_total;
        push_frame(1'b0, 14'h2ABC);
        strobe(1'b1, 14'h2ABC, 1'b0, 14'h0);
        wait_idle("t1");
        check("t1_sends", send_total - s0, 3);
        check("t1_count", {16'h0, o_frame_count}, 32'd1);
        check("t1_busy", {31'h0, o_busy}, 32'h0);

        // Simultaneous pair after ch1 was last served: ch2 goes first.
        push_frame(1'b1, 14'h3FFF);
        push_frame(1'b0, 14'h0001);
        strobe(1'b1, 14'h0001, 1'b1, 14'h3FFF);
        wait_idle("t2a");
        check("t2a_count", {16'h0, o_frame_count}, 32'd3);

        // Simultaneous pair fresh from reset: ch1 goes first.
        do_reset("rst1");
        push_frame(1'b0, 14'h0001);
        push_frame(1'b1, 14'h3FFF);
        strobe(1'b1, 14'h0001, 1'b1, 14'h3FFF);
        wait_idle("t2b");
        check("t2b_count", {16'h0, o_frame_count}, 32'd2);

        // Second ch2 sample while the first is still pending is dropped.
        push_frame(1'b0, 14'h1234);
        push_frame(1'b1, 14'h0100);
        strobe(1'b1, 14'h1234, 1'b0, 14'h0);
        repeat (3) @(negedge i_clock);
        strobe(1'b0, 14'h0, 1'b1, 14'h0100);
        repeat (2) @(negedge i_clock);
        strobe(1'b0, 14'h0, 1'b1, 14'h0200);
        check("t3_ovf2_set", {31'h0, o_overflow_ch2}, 32'h1);
        check("t3_ovf1_clear", {31'h0, o_overflow_ch1}, 32'h0);
        wait_idle("t3");
        check("t3_ovf2_sticky", {31'h0, o_overflow_ch2}, 32'h1);
        check("t3_ovf1_still_clear", {31'h0, o_overflow_ch1}, 32'h0);
        check("t3_count", {16'h0, o_frame_count}, 32'd4);

        // ch1 strobe on the same edge its pending sample is granted.
        push_frame(1'b0, 14'h1111);
        push_frame(1'b0, 14'h2222);
        strobe(1'b1, 14'h1111, 1'b0, 14'h0);
        strobe(1'b1, 14'h2222, 1'b0, 14'h0);
        wait_idle("t4");
        check("t4_ovf1", {31'h0, o_overflow_ch1}, 32'h0);
        check("t4_count", {16'h0, o_frame_count}, 32'd6);

        // Enable dropped with ch1 pending behind a ch2 frame.
        push_frame(1'b1, 14'h0555);
        push_frame(1'b0, 14'h0777);
        strobe(1'b0, 14'h0, 1'b1, 14'h0555);
        strobe(1'b1, 14'h0777, 1'b0, 14'h0);
        i_enable = 1'b0;
        strobe(1'b1, 14'h0999, 1'b1, 14'h0AAA);
        repeat (4) @(negedge i_clock);
        strobe(1'b1, 14'h0999, 1'b1, 14'h0AAA);
        check("t5_busy_during", {31'h0, o_busy}, 32'h1);
        wait_idle("t5");
        check("t5_ovf1", {31'h0, o_overflow_ch1}, 32'h0);
        check("t5_count", {16'h0, o_frame_count}, 32'd8);
        check("t5_busy_after", {31'h0, o_busy}, 32'h0);
        i_enable = 1'b1;

        // Reset during the HI byte send.
        exp_q.push_back(8'hA4);
        exp_q.push_back(8'h13);
        strobe(1'b1, 14'h1357, 1'b0, 14'h0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge i_clock);
            if (o_send === 1'b1 && o_txdata === 8'h13) found = 1'b1;
        end
        check("t6_hi_send_seen", {31'h0, found}, 32'h1);
        #1;
        i_reset  = 1'b0;
        tx_stall = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        drain();
        check("t6_partial_bytes", exp_q.size(), 0);
        repeat (3) @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        s0 = send_total;
        repeat (5) @(negedge i_clock);
        strobe(1'b1, 14'h0246, 1'b0, 14'h0);
        repeat (20) @(negedge i_clock);
        check("t6_no_send_while_stalled", send_total - s0, 0);
        check("t6_busy_pending", {31'h0, o_busy}, 32'h1);
        push_frame(1'b0, 14'h0246);
        tx_stall = 1'b0;
        wait_idle("t6");
        check("t6_sends", send_total - s0, 3);
        check("t6_count", {16'h0, o_frame_count}, 32'd1);
        check("send_vs_ready", viol_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
